if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 32-bit pipelined MIPS core: owns the program counter, drives instruction memory, and loads the IF/ID pipeline register (`IF_ID_Inst`, `IF_ID_PCPlus4`). It sits directly upstream of the ID-stage jump decoder. It consumes that decoder's `PCSrc`/`JmpAddr` redirect, plus the EX-stage branch redirect and the hazard-unit stall. On any redirect it squashes the wrong-path fetch.

---
 rtl/if_fetch_stage.sv | 89 ++++++++
 tb/tb_if_fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the
// IF/ID register, squashing the wrong-path fetch on a branch or jump redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] JmpAddr,
    input  logic        BrTaken,
    input  logic [31:0] BrTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc_plus4;
    logic [31:0] pc_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] pcplus4_nxt;
    logic        valid_nxt;

    assign pc_plus4  = PC + 32'd4;
    assign imem_req  = (state == FETCH);
    assign imem_addr = PC;

    // Redirect priority: the EX branch is older than anything in ID, so it beats stall.
    always_comb begin
        // NOTE: every next-value gets a hold default first so no latch is inferred.
        pc_nxt      = PC;
        inst_nxt    = IF_ID_Inst;
        pcplus4_nxt = IF_ID_PCPlus4;
        valid_nxt   = IF_ID_Valid;
        if (state == FETCH) begin
            if (BrTaken) begin
                pc_nxt      = BrTarget;
                inst_nxt    = NOP_INST;
                pcplus4_nxt = 32'd0;
                valid_nxt   = 1'b0;
            end else if (stall) begin
                pc_nxt = PC;
            end else if (PCSrc) begin
                pc_nxt      = JmpAddr;
                inst_nxt    = NOP_INST;
                pcplus4_nxt = 32'd0;
                valid_nxt   = 1'b0;
            end else if (imem_ready) begin
                pc_nxt      = pc_plus4;
                inst_nxt    = imem_data;
                pcplus4_nxt = pc_plus4;
                valid_nxt   = 1'b1;
            end else begin
                // Memory not ready: insert a bubble so ID never re-executes a stale word.
                inst_nxt    = NOP_INST;
                pcplus4_nxt = 32'd0;
                valid_nxt   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state         <= IDLE;
            PC            <= RESET_PC;
            IF_ID_Inst    <= NOP_INST;
            IF_ID_PCPlus4 <= 32'd0;
            IF_ID_Valid   <= 1'b0;
        end else begin
            state         <= FETCH;
            PC            <= pc_nxt;
            IF_ID_Inst    <= inst_nxt;
            IF_ID_PCPlus4 <= pcplus4_nxt;
            IF_ID_Valid   <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage with hand-computed expectations.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        PCSrc;
    logic [31:0] JmpAddr;
    logic        BrTaken;
    logic [31:0] BrTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] PC;
    logic [31:0] IF_ID_Inst;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .PCSrc         (PCSrc),
        .JmpAddr       (JmpAddr),
        .BrTaken       (BrTaken),
        .BrTarget      (BrTarget),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .imem_ready    (imem_ready),
        .PC            (PC),
        .IF_ID_Inst    (IF_ID_Inst),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid)
    );

    typedef struct {
        logic        st;
        logic        js;
        logic [31:0] jmp;
        logic        br;
        logic [31:0] brt;
        logic        rdy;
        logic [31:0] data;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_pp4;
        logic        e_v;
        logic        e_req;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic js, input logic [31:0] jmp,
                                input logic br, input logic [31:0] brt,
                                input logic rdy, input logic [31:0] data,
                                input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic [31:0] e_pp4, input logic e_v, input logic e_req);
        vec_t t;
        t.st = st; t.js = js; t.jmp = jmp; t.br = br; t.brt = brt;
        t.rdy = rdy; t.data = data;
        t.e_pc = e_pc; t.e_inst = e_inst; t.e_pp4 = e_pp4; t.e_v = e_v; t.e_req = e_req;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [97:0] act, input logic [97:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] {req,pc,inst,pp4,v} got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input string name, input int idx, input logic rst, input vec_t t);
        @(negedge clk);
        reset      = rst;
        stall      = t.st;
        PCSrc      = t.js;
        JmpAddr    = t.jmp;
        BrTaken    = t.br;
        BrTarget   = t.brt;
        imem_ready = t.rdy;
        imem_data  = t.data;
        @(posedge clk);
        #1;
        check(name, idx, {imem_req, PC, IF_ID_Inst, IF_ID_PCPlus4, IF_ID_Valid},
                         {t.e_req, t.e_pc, t.e_inst, t.e_pp4, t.e_v});
        checks++;
        if (imem_addr !== PC) begin
            failures++;
            $display("FAIL %s_addr[%0d] imem_addr=%h pc=%h", name, idx, imem_addr, PC);
        end
    endtask

    initial begin
        // st js jmp  br brt  rdy data | pc inst pp4 v req
        // IDLE edge: a branch here must be ignored
        vecs.push_back(mk(0,0,0, 1,32'h40, 1,32'h1234_5678, 32'h0, 32'h0, 32'h0, 0, 1));
        // sequential fetch
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h2001_0005, 32'h4,  32'h2001_0005, 32'h4,  1, 1));
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h2002_0007, 32'h8,  32'h2002_0007, 32'h8,  1, 1));
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h0022_1820, 32'hC,  32'h0022_1820, 32'hC,  1, 1));
        // jump word into IF/ID, then redirect; wrong-path word discarded
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h0800_0010, 32'h10, 32'h0800_0010, 32'h10, 1, 1));
        vecs.push_back(mk(0,1,32'h10, 0,0, 1,32'hDEAD_BEEF, 32'h10, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0, 1,32'hAAAA_0001, 32'h14, 32'hAAAA_0001, 32'h14, 1, 1));
        // simultaneous branch and jump: branch wins
        vecs.push_back(mk(0,1,32'h80, 1,32'h40, 1,32'hDEAD_BEEF, 32'h40, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h1111_0040, 32'h44, 32'h1111_0040, 32'h44, 1, 1));
        // stall 3 cycles with pending jump, then release
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h0800_0020, 32'h48, 32'h0800_0020, 32'h48, 1, 1));
        vecs.push_back(mk(1,1,32'h20, 0,0, 1,32'hBAD0_0001, 32'h48, 32'h0800_0020, 32'h48, 1, 1));
        vecs.push_back(mk(1,1,32'h20, 0,0, 1,32'hBAD0_0002, 32'h48, 32'h0800_0020, 32'h48, 1, 1));
        vecs.push_back(mk(1,1,32'h20, 0,0, 1,32'hBAD0_0003, 32'h48, 32'h0800_0020, 32'h48, 1, 1));
        vecs.push_back(mk(0,1,32'h20, 0,0, 1,32'hBAD0_0004, 32'h20, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h2222_0020, 32'h24, 32'h2222_0020, 32'h24, 1, 1));
        // branch during stall redirects at once
        vecs.push_back(mk(1,0,0, 1,32'h8, 1,32'hBAD0_0005, 32'h8, 32'h0, 32'h0, 0, 1));
        // memory wait at PC=8, then load
        vecs.push_back(mk(0,0,0, 0,0, 0,32'hBAD0_0006, 32'h8, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0, 0,32'hBAD0_0007, 32'h8, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h3333_0008, 32'hC, 32'h3333_0008, 32'hC, 1, 1));
        // jump during a wait: late word discarded
        vecs.push_back(mk(0,0,0, 0,0, 0,32'hBAD0_0008, 32'hC, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(0,1,32'h30, 0,0, 1,32'h4444_0000, 32'h30, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h5555_0030, 32'h34, 32'h5555_0030, 32'h34, 1, 1));
        // wrap: branch to top of address space, one fetch wraps PC to 0
        vecs.push_back(mk(0,0,0, 1,32'hFFFF_FFFC, 1,32'hBAD0_0009, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(0,0,0, 0,0, 1,32'h6666_6666, 32'h0, 32'h6666_6666, 32'h0, 1, 1));

        // reset state (inputs deliberately active to show reset overrides them)
        apply("reset", 0, 1'b1, mk(0,1,32'h80, 1,32'h40, 1,32'h7777_7777, 32'h0, 32'h0, 32'h0, 0, 0));

        foreach (vecs[i]) apply("vec", i, 1'b0, vecs[i]);

        // reset mid-run at PC=0x24
        apply("mid", 0, 1'b0, mk(0,0,0, 1,32'h20, 1,32'h0, 32'h20, 32'h0, 32'h0, 0, 1));
        apply("mid", 1, 1'b0, mk(0,0,0, 0,0, 1,32'h8888_0020, 32'h24, 32'h8888_0020, 32'h24, 1, 1));
        apply("mid", 2, 1'b1, mk(1,1,32'h80, 1,32'h40, 1,32'h9999_0024, 32'h0, 32'h0, 32'h0, 0, 0));
        apply("mid", 3, 1'b0, mk(0,0,0, 1,32'h40, 1,32'h9999_0000, 32'h0, 32'h0, 32'h0, 0, 1));
        apply("mid", 4, 1'b0, mk(0,0,0, 0,0, 1,32'hABCD_0000, 32'h4, 32'hABCD_0000, 32'h4, 1, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
